// File: rtl/vgacon_stream_ctrl.sv
// vgacon_stream_ctrl: console char stream -> 9-bit text buffer, with cursor and
// a scroll/clear engine. Host writes always win the single buffer write port.
// Ports: char_data/valid/ready (producer), host_wr_en/addr/data (priority writes),
// buf_we/waddr/wdata + buf_raddr/rdata (buffer), vblank, cursor_row/col, busy.
// Optional macro VGACON_VBLANK_SYNC_EN: scroll/clear wait for vblank before starting.
module vgacon_stream_ctrl #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 10,
  parameter logic [8:0] BLANK = 9'h020,
  parameter int AW = $clog2(NUM_ROWS*NUM_COLS),
  localparam int RW = $clog2(NUM_ROWS),
  localparam int CW = $clog2(NUM_COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [8:0]    char_data,
  input  logic          char_valid,
  output logic          char_ready,
  input  logic          host_wr_en,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [8:0]    host_wr_data,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic [8:0]    buf_wdata,
  output logic [AW-1:0] buf_raddr,
  input  logic [8:0]    buf_rdata,
  input  logic          vblank,
  output logic [RW-1:0] cursor_row,
  output logic [CW-1:0] cursor_col,
  output logic          busy
);

  localparam int NCH = NUM_ROWS*NUM_COLS;
  localparam logic [AW-1:0] CP_LAST   = AW'(NCH-NUM_COLS-1);
  localparam logic [AW-1:0] CELL_LAST = AW'(NCH-1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(NUM_ROWS-1);
  localparam logic [CW-1:0] COL_LAST  = CW'(NUM_COLS-1);

  typedef enum logic [2:0] {
    S_IDLE, S_COPY, S_FILL, S_CLR, S_WVBL
  } state_t;

  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_idx, w_idx_nx;
  logic [RW-1:0] r_row, w_row_nx;
  logic [CW-1:0] r_col, w_col_nx;
  logic          w_acc, w_prn, w_go_scr, w_go_clr;
  logic [6:0]    w_asc;
  logic [AW-1:0] w_cur_addr;

`ifdef VGACON_VBLANK_SYNC_EN
  // Remembers which operation WAIT_VBL is holding back.
  logic r_clr, w_clr_nx;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
`endif

  assign char_ready = (r_state == S_IDLE) & ~host_wr_en;
  assign busy       = (r_state != S_IDLE);
  assign cursor_row = r_row;
  assign cursor_col = r_col;
  assign w_acc      = char_valid & char_ready;
  assign w_asc      = char_data[6:0];
  assign w_prn      = (w_asc >= 7'h20) && (w_asc <= 7'h7E);
  assign w_cur_addr = AW'(int'(r_row)*NUM_COLS + int'(r_col));
  // Copy source is one row below the destination.
  assign buf_raddr  = (r_state == S_COPY) ? r_idx + AW'(NUM_COLS) : '0;

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_row_nx   = r_row;
    w_col_nx   = r_col;
    w_go_scr   = 1'b0;
    w_go_clr   = 1'b0;
`ifdef VGACON_VBLANK_SYNC_EN
    w_clr_nx   = r_clr;
`endif
    if (w_acc) begin
      unique case (1'b1)
        w_prn: begin
          if (r_col == COL_LAST) begin
            w_col_nx = '0;
            if (r_row == ROW_LAST) w_go_scr = 1'b1;
            else w_row_nx = r_row + RW'(1);
          end else begin
            w_col_nx = r_col + CW'(1);
          end
        end
        (w_asc == 7'h0D): w_col_nx = '0;
        (w_asc == 7'h0A): begin
          if (r_row == ROW_LAST) w_go_scr = 1'b1;
          else w_row_nx = r_row + RW'(1);
        end
        (w_asc == 7'h08): begin
          if (r_col != '0) w_col_nx = r_col - CW'(1);
        end
        (w_asc == 7'h0C): begin
          w_row_nx = '0;
          w_col_nx = '0;
          w_go_clr = 1'b1;
        end
        default: ;
      endcase
    end
    case (r_state)
      S_IDLE: begin
        if (w_go_scr || w_go_clr) begin
          w_idx_nx = '0;
`ifdef VGACON_VBLANK_SYNC_EN
          w_state_nx = S_WVBL;
          w_clr_nx   = w_go_clr;
`else
          w_state_nx = w_go_clr ? S_CLR : S_COPY;
`endif
        end
      end
      S_COPY: begin
        if (!host_wr_en) begin
          w_idx_nx = r_idx + AW'(1);
          if (r_idx == CP_LAST) w_state_nx = S_FILL;
        end
      end
      S_FILL, S_CLR: begin
        if (!host_wr_en) begin
          if (r_idx == CELL_LAST) begin
            w_state_nx = S_IDLE;
            w_idx_nx   = '0;
          end else begin
            w_idx_nx = r_idx + AW'(1);
          end
        end
      end
`ifdef VGACON_VBLANK_SYNC_EN
      S_WVBL: begin
        if (vblank) w_state_nx = r_clr ? S_CLR : S_COPY;
      end
`endif
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = '0;
    buf_wdata = '0;
    if (host_wr_en) begin
      buf_we    = 1'b1;
      buf_waddr = host_wr_addr;
      buf_wdata = host_wr_data;
    end else if (w_acc && w_prn) begin
      buf_we    = 1'b1;
      buf_waddr = w_cur_addr;
      buf_wdata = char_data;
    end else begin
      case (r_state)
        S_COPY: begin
          buf_we    = 1'b1;
          buf_waddr = r_idx;
          buf_wdata = buf_rdata;
        end
        S_FILL, S_CLR: begin
          buf_we    = 1'b1;
          buf_waddr = r_idx;
          buf_wdata = BLANK;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_row   <= '0;
      r_col   <= '0;
`ifdef VGACON_VBLANK_SYNC_EN
      r_clr   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_row   <= w_row_nx;
      r_col   <= w_col_nx;
`ifdef VGACON_VBLANK_SYNC_EN
      r_clr   <= w_clr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_vgacon_stream_ctrl.sv
// tb_vgacon_stream_ctrl: randomized bench for vgacon_stream_ctrl with a text
// buffer model and a cell-level console reference model.
module tb_vgacon_stream_ctrl;

  localparam int NR  = 3;
  localparam int NCL = 10;
  localparam int NCH = 30;
  localparam logic [8:0] BLANK = 9'h020;
`ifdef VGACON_VBLANK_SYNC_EN
  localparam logic VBL_IDLE = 1'b1;
  localparam int WCY = 1;
  localparam int ABORT_K = 4;
`else
  localparam logic VBL_IDLE = 1'b0;
  localparam int WCY = 0;
  localparam int ABORT_K = 5;
`endif

  logic clk = 1'b0;
  logic rst, char_valid, char_ready, host_wr_en;
  logic buf_we, vblank, busy;
  logic [8:0] char_data, host_wr_data, buf_wdata, buf_rdata;
  logic [4:0] host_wr_addr, buf_waddr, buf_raddr;
  logic [1:0] cursor_row;
  logic [3:0] cursor_col;

  int n_vec = 0;
  int n_err = 0;
  int er = 0;
  int ec = 0;
  logic [8:0] exp_mem [NCH];
  logic [8:0] mem [NCH];

  always #5 clk = ~clk;

  vgacon_stream_ctrl dut (
    .clk(clk), .rst(rst),
    .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data),
    .buf_we(buf_we), .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata), .buf_raddr(buf_raddr),
    .buf_rdata(buf_rdata), .vblank(vblank),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .busy(busy)
  );

  // Text buffer: synchronous write, combinational read.
  assign buf_rdata = (buf_raddr < 5'd30) ? mem[buf_raddr] : 9'h0;
  always @(posedge clk)
    if (buf_we && buf_waddr < 5'd30) mem[buf_waddr] <= buf_wdata;

  // Reference console: whole-screen effect of one accepted character.
  task automatic model_char(input logic [8:0] ch);
    int a;
    bit scr, clr;
    a = int'(ch[6:0]);
    scr = 0;
    clr = 0;
    if (a >= 32 && a <= 126) begin
      exp_mem[er*NCL+ec] = ch;
      ec++;
      if (ec == NCL) begin
        ec = 0;
        if (er == NR-1) scr = 1; else er++;
      end
    end else if (a == 13) ec = 0;
    else if (a == 10) begin
      if (er == NR-1) scr = 1; else er++;
    end else if (a == 8) begin
      if (ec > 0) ec--;
    end else if (a == 12) begin
      er = 0; ec = 0; clr = 1;
    end
    if (scr) begin
      for (int k = 0; k < NCH-NCL; k++) exp_mem[k] = exp_mem[k+NCL];
      for (int k = NCH-NCL; k < NCH; k++) exp_mem[k] = BLANK;
    end
    if (clr)
      for (int k = 0; k < NCH; k++) exp_mem[k] = BLANK;
  endtask

  task automatic send(input logic [8:0] ch, output logic we,
                      output logic [4:0] wa, output logic [8:0] wd,
                      output bit to);
    int n;
    n = 0;
    char_data = ch;
    char_valid = 1'b1;
    #1;
    while (!char_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    to = !char_ready;
    we = buf_we;
    wa = buf_waddr;
    wd = buf_wdata;
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1; n++;
    end
    to = busy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    er = 0; ec = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; host_wr_en = 1'b0; char_valid = 1'b0;
    char_data = '0; host_wr_addr = '0; host_wr_data = '0;
    vblank = VBL_IDLE;
    #1;
    n_vec++;
    if (busy !== 1'b0 || cursor_row !== 2'd0 || cursor_col !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b row=%0d col=%0d want 0,0,0",
               busy, cursor_row, cursor_col);
    end
    n_vec++;
    if (char_ready !== 1'b1 || buf_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ports: ready=%b we=%b want 1,0", char_ready, buf_we);
    end
    host_wr_en = 1'b1; host_wr_addr = 5'd7; host_wr_data = 9'h1AB;
    #1;
    n_vec++;
    if (buf_we !== 1'b1 || buf_waddr !== 5'd7 || buf_wdata !== 9'h1AB ||
        char_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_host: we=%b a=%0d d=%h rdy=%b want 1,7,1ab,0",
               buf_we, buf_waddr, buf_wdata, char_ready);
    end
    host_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || cursor_row !== 2'd0 || cursor_col !== 4'd0) begin
      n_err++;
      $display("FAIL reset_release: busy=%b row=%0d col=%0d want 0,0,0",
               busy, cursor_row, cursor_col);
    end
  endtask

  // Fill the buffer through host writes while a character is offered.
  task automatic test_host_preload();
    logic [8:0] d;
    char_data = 9'h041;
    char_valid = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      d = 9'($urandom);
      host_wr_en = 1'b1; host_wr_addr = 5'(i); host_wr_data = d;
      #1;
      n_vec++;
      if (buf_we !== 1'b1 || buf_waddr !== 5'(i) || buf_wdata !== d ||
          char_ready !== 1'b0) begin
        n_err++;
        $display("FAIL host_fwd%0d: we=%b a=%0d d=%h rdy=%b want 1,%0d,%h,0",
                 i, buf_we, buf_waddr, buf_wdata, char_ready, i, d);
      end
      exp_mem[i] = d;
      @(posedge clk); #1;
    end
    host_wr_en = 1'b0;
    char_valid = 1'b0;
    n_vec++;
    if (cursor_row !== 2'(er) || cursor_col !== 4'(ec)) begin
      n_err++;
      $display("FAIL host_priority_cursor: got %0d,%0d want %0d,%0d",
               cursor_row, cursor_col, er, ec);
    end
  endtask

  task automatic test_hi();
    logic we; logic [4:0] wa; logic [8:0] wd; bit to;
    send(9'h0C8, we, wa, wd, to);
    n_vec++;
    if (to || we !== 1'b1 || wa !== 5'd0 || wd !== 9'h0C8) begin
      n_err++;
      $display("FAIL hi_H: to=%0d we=%b a=%0d d=%h want 1,0,0c8", to, we, wa, wd);
    end
    model_char(9'h0C8);
    send(9'h0E9, we, wa, wd, to);
    n_vec++;
    if (to || we !== 1'b1 || wa !== 5'd1 || wd !== 9'h0E9) begin
      n_err++;
      $display("FAIL hi_i: to=%0d we=%b a=%0d d=%h want 1,1,0e9", to, we, wa, wd);
    end
    model_char(9'h0E9);
    n_vec++;
    if (cursor_row !== 2'd0 || cursor_col !== 4'd2) begin
      n_err++;
      $display("FAIL hi_cursor: got %0d,%0d want 0,2", cursor_row, cursor_col);
    end
  endtask

  task automatic test_row_wrap();
    logic we; logic [4:0] wa; logic [8:0] wd; bit to;
    logic [8:0] ch;
    do_reset();
    for (int i = 0; i < NCL; i++) begin
      ch = {2'($urandom), 7'($urandom_range(32, 126))};
      send(ch, we, wa, wd, to);
      n_vec++;
      if (to || we !== 1'b1 || wa !== 5'(i) || wd !== ch) begin
        n_err++;
        $display("FAIL wrap_wr%0d: we=%b a=%0d d=%h want 1,%0d,%h",
                 i, we, wa, wd, i, ch);
      end
      model_char(ch);
    end
    n_vec++;
    if (busy !== 1'b0 || cursor_row !== 2'd1 || cursor_col !== 4'd0) begin
      n_err++;
      $display("FAIL wrap_cursor: busy=%b pos=%0d,%0d want 0,1,0",
               busy, cursor_row, cursor_col);
    end
  endtask

  task automatic test_scroll();
    logic we; logic [4:0] wa; logic [8:0] wd; bit to;
    logic [8:0] ch;
    int n, nw, rdy_hi;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ch = {2'($urandom), 7'($urandom_range(32, 126))};
      send(ch, we, wa, wd, to);
      model_char(ch);
    end
    repeat (2) begin
      send(9'h00A, we, wa, wd, to);
      model_char(9'h00A);
    end
    n_vec++;
    if (cursor_row !== 2'd2 || cursor_col !== 4'd3) begin
      n_err++;
      $display("FAIL scroll_pre: got %0d,%0d want 2,3", cursor_row, cursor_col);
    end
    send(9'h00A, we, wa, wd, to);
    n_vec++;
    if (to || we !== 1'b0) begin
      n_err++;
      $display("FAIL scroll_lf_write: to=%0d we=%b want 0", to, we);
    end
    model_char(9'h00A);
    n = 0; nw = 0; rdy_hi = 0;
    while (busy && n < 200) begin
      if (buf_we) nw++;
      if (char_ready) rdy_hi++;
      n++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (n != 30 + WCY || nw != 30 || rdy_hi != 0) begin
      n_err++;
      $display("FAIL scroll_len: busy=%0d writes=%0d ready_hi=%0d want %0d,30,0",
               n, nw, rdy_hi, 30 + WCY);
    end
    n_vec++;
    if (cursor_row !== 2'd2 || cursor_col !== 4'd3) begin
      n_err++;
      $display("FAIL scroll_cursor: got %0d,%0d want 2,3", cursor_row, cursor_col);
    end
    for (int k = 0; k < NCH; k++) begin
      n_vec++;
      if (mem[k] !== exp_mem[k]) begin
        n_err++;
        $display("FAIL scroll_cell%0d: got %h want %h", k, mem[k], exp_mem[k]);
      end
    end
  endtask

  task automatic test_scroll_stall();
    logic we; logic [4:0] wa; logic [8:0] wd; bit to;
    int n, nw;
    send(9'h00A, we, wa, wd, to);
    // The host write lands before cell 5 is copied into, so it is overwritten.
    exp_mem[5] = 9'h141;
    model_char(9'h00A);
    n = 0; nw = 0;
    while (busy && n < 200) begin
      if (n == 2) begin
        host_wr_en = 1'b1; host_wr_addr = 5'd5; host_wr_data = 9'h141;
        #1;
        n_vec++;
        if (buf_we !== 1'b1 || buf_waddr !== 5'd5 || buf_wdata !== 9'h141) begin
          n_err++;
          $display("FAIL stall_host: we=%b a=%0d d=%h want 1,5,141",
                   buf_we, buf_waddr, buf_wdata);
        end
      end else begin
        host_wr_en = 1'b0;
      end
      if (buf_we) nw++;
      n++;
      @(posedge clk); #1;
    end
    host_wr_en = 1'b0;
    n_vec++;
    if (n != 31 + WCY || nw != 31) begin
      n_err++;
      $display("FAIL stall_len: busy=%0d writes=%0d want %0d,31", n, nw, 31 + WCY);
    end
    for (int k = 0; k < NCH; k++) begin
      n_vec++;
      if (mem[k] !== exp_mem[k]) begin
        n_err++;
        $display("FAIL stall_cell%0d: got %h want %h", k, mem[k], exp_mem[k]);
      end
    end
  endtask

  task automatic test_clear_bs();
    logic we; logic [4:0] wa; logic [8:0] wd; bit to;
    int n;
    send(9'h00C, we, wa, wd, to);
    model_char(9'h00C);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (n != 30 + WCY) begin
      n_err++;
      $display("FAIL clear_len: got %0d want %0d", n, 30 + WCY);
    end
    send(9'h008, we, wa, wd, to);
    model_char(9'h008);
    n_vec++;
    if (to || we !== 1'b0 || cursor_row !== 2'd0 || cursor_col !== 4'd0) begin
      n_err++;
      $display("FAIL bs_col0: to=%0d we=%b pos=%0d,%0d want 0,0,0",
               to, we, cursor_row, cursor_col);
    end
    for (int k = 0; k < NCH; k++) begin
      n_vec++;
      if (mem[k] !== BLANK) begin
        n_err++;
        $display("FAIL clear_cell%0d: got %h want %h", k, mem[k], BLANK);
      end
    end
  endtask

`ifdef VGACON_VBLANK_SYNC_EN
  task automatic test_vblank();
    logic we; logic [4:0] wa; logic [8:0] wd; bit to;
    int n, nw, bad;
    vblank = 1'b0;
    send(9'h00C, we, wa, wd, to);
    model_char(9'h00C);
    bad = 0;
    repeat (10) begin
      if (busy !== 1'b1 || buf_we !== 1'b0 || char_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL vbl_wait: %0d bad cycles want 0", bad);
    end
    vblank = 1'b1;
    @(posedge clk); #1;
    vblank = 1'b0;
    n = 0; nw = 0;
    while (busy && n < 200) begin
      if (buf_we) nw++;
      n++;
      @(posedge clk); #1;
    end
    vblank = VBL_IDLE;
    n_vec++;
    if (n != 30 || nw != 30) begin
      n_err++;
      $display("FAIL vbl_clear: busy=%0d writes=%0d want 30,30", n, nw);
    end
  endtask
`else
  task automatic test_vblank();
    logic we; logic [4:0] wa; logic [8:0] wd; bit to;
    vblank = 1'b0;
    send(9'h00C, we, wa, wd, to);
    model_char(9'h00C);
    n_vec++;
    if (busy !== 1'b1 || buf_we !== 1'b1 || buf_waddr !== 5'd0 ||
        buf_wdata !== BLANK) begin
      n_err++;
      $display("FAIL vbl_ignored: busy=%b we=%b a=%0d d=%h want 1,1,0,020",
               busy, buf_we, buf_waddr, buf_wdata);
    end
    wait_idle(to);
    n_vec++;
    if (to) begin
      n_err++;
      $display("FAIL vbl_ignored_idle: busy=1 want 0");
    end
  endtask
`endif

  task automatic test_abort();
    logic we; logic [4:0] wa; logic [8:0] wd; bit to;
    send(9'h00C, we, wa, wd, to);
    er = 0; ec = 0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || cursor_row !== 2'd0 || cursor_col !== 4'd0 ||
        char_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort: busy=%b pos=%0d,%0d rdy=%b want 0,0,0,1",
               busy, cursor_row, cursor_col, char_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < ABORT_K; k++) exp_mem[k] = BLANK;
    for (int k = 0; k < NCH; k++) begin
      n_vec++;
      if (mem[k] !== exp_mem[k]) begin
        n_err++;
        $display("FAIL abort_cell%0d: got %h want %h", k, mem[k], exp_mem[k]);
      end
    end
  endtask

  task automatic test_random();
    logic we; logic [4:0] wa; logic [8:0] wd; bit to, prn;
    logic [8:0] ch;
    logic [6:0] oth [5];
    int r;
    oth[0] = 7'h00; oth[1] = 7'h07; oth[2] = 7'h09;
    oth[3] = 7'h1B; oth[4] = 7'h7F;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      ch[8:7] = 2'($urandom);
      if (r < 60) ch[6:0] = 7'($urandom_range(32, 126));
      else if (r < 70) ch[6:0] = 7'h0D;
      else if (r < 82) ch[6:0] = 7'h0A;
      else if (r < 90) ch[6:0] = 7'h08;
      else if (r < 93) ch[6:0] = 7'h0C;
      else ch[6:0] = oth[$urandom_range(0, 4)];
      prn = (ch[6:0] >= 7'h20) && (ch[6:0] <= 7'h7E);
      send(ch, we, wa, wd, to);
      n_vec++;
      if (to || we !== prn ||
          (prn && (wa !== 5'(er*NCL+ec) || wd !== ch))) begin
        n_err++;
        $display("FAIL rnd_wr%0d ch=%h: to=%0d we=%b a=%0d d=%h want %b,%0d",
                 i, ch, to, we, wa, wd, prn, er*NCL+ec);
      end
      model_char(ch);
      wait_idle(to);
      n_vec++;
      if (to || cursor_row !== 2'(er) || cursor_col !== 4'(ec)) begin
        n_err++;
        $display("FAIL rnd_cur%0d ch=%h: to=%0d got %0d,%0d want %0d,%0d",
                 i, ch, to, cursor_row, cursor_col, er, ec);
      end
    end
    for (int k = 0; k < NCH; k++) begin
      n_vec++;
      if (mem[k] !== exp_mem[k]) begin
        n_err++;
        $display("FAIL rnd_cell%0d: got %h want %h", k, mem[k], exp_mem[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_host_preload();
    test_hi();
    test_row_wrap();
    test_scroll();
    test_scroll_stall();
    test_clear_bs();
    test_vblank();
    test_host_preload();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
